// File: rtl/fft_dir_pkg.sv
// Shared types and arithmetic helpers for the FFT direction/scaling wrapper.
// Helpers work in 32-bit signed so they serve any sample width up to 31 bits.
package fft_dir_pkg;

    localparam int SAMPLE_DW = 16;

    typedef enum logic {
        FWD = 1'b0,
        INV = 1'b1
    } mode_e;

    typedef struct packed {
        logic signed [SAMPLE_DW-1:0] re;
        logic signed [SAMPLE_DW-1:0] im;
    } sample_t;

    // Negate a dw-bit value; the most negative code maps to the most positive.
    function automatic logic signed [31:0] sat_neg(input logic signed [31:0] x, input int dw);
        logic signed [31:0] w_min;
        w_min = -(32'sd1 <<< (dw - 1));
        return (x == w_min) ? ~w_min : -x;
    endfunction

    function automatic logic signed [31:0] scale_shift(input logic signed [31:0] x, input int log2n,
                                                       input bit rnd);
        logic signed [31:0] w_bias;
        w_bias = rnd ? (32'sd1 <<< (log2n - 1)) : 32'sd0;
        return (x + w_bias) >>> log2n;
    endfunction

endpackage

// File: rtl/fft_mode_fifo.sv
// Per-frame direction FIFO, 1 bit wide, DEPTH entries.
// Latency: head visible the cycle after push. Backpressure: push ignored when full, pop ignored when empty.
module fft_mode_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_push,
    input  logic i_din,
    input  logic i_pop,
    output logic o_dout,
    output logic o_full,
    output logic o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] r_mem;
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push && !o_full) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_din;
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (i_pop && !o_empty) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fft_dir_stream.sv
// Per-frame forward/inverse wrapper around a forward-only FFT core (swap-conjugate, 1/N scale).
// Latency: input path combinational; output registered, 1 cycle after the core handshake.
// Backpressure: in_ready follows core_in_ready, held off at frame start when the mode FIFO is full.
module fft_dir_stream
    import fft_dir_pkg::*;
#(
    parameter int DW         = 16,
    parameter int LOG2N      = 5,
    parameter int MODE_DEPTH = 4,
    parameter int ROUND      = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inverse_i,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_real,
    input  logic signed [DW-1:0] in_imag,
    output logic                 core_in_valid,
    input  logic                 core_in_ready,
    output logic signed [DW-1:0] core_in_real,
    output logic signed [DW-1:0] core_in_imag,
    input  logic                 core_out_valid,
    output logic                 core_out_ready,
    input  logic signed [DW-1:0] core_out_real,
    input  logic signed [DW-1:0] core_out_imag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_real,
    output logic signed [DW-1:0] out_imag,
    output logic                 out_last,
    output logic                 frame_done,
    output logic                 busy
);

    localparam int               N    = 2 ** LOG2N;
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    logic [LOG2N-1:0]     r_in_cnt;
    logic [LOG2N-1:0]     r_out_cnt;
    mode_e                r_in_mode;
    logic                 r_out_valid;
    logic                 r_out_last;
    logic                 r_frame_done;
    logic signed [DW-1:0] r_out_real;
    logic signed [DW-1:0] r_out_imag;

    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_fifo_head;
    logic                 w_in_first;
    logic                 w_in_hs;
    logic                 w_out_hs;
    logic                 w_push;
    logic                 w_pop;
    mode_e                w_in_mode;
    mode_e                w_out_mode;
    logic signed [DW-1:0] w_neg_real;
    logic signed [DW-1:0] w_scl_real;
    logic signed [DW-1:0] w_scl_imag;

    // Input side: the first sample of a frame uses the live request, the rest use the latched one.
    assign w_in_first    = (r_in_cnt == '0);
    assign w_in_mode     = w_in_first ? mode_e'(inverse_i) : r_in_mode;
    assign in_ready      = core_in_ready && !(w_in_first && w_fifo_full);
    assign core_in_valid = in_valid && in_ready;
    assign w_in_hs       = core_in_valid;
    assign w_push        = w_in_hs && w_in_first;

    assign w_neg_real    = DW'(sat_neg(32'(in_real), DW));
    assign core_in_real  = (w_in_mode == INV) ? in_imag : in_real;
    assign core_in_imag  = (w_in_mode == INV) ? w_neg_real : in_imag;

    // Output side: with no queued mode the core is stalled rather than emit an unknown direction.
    assign core_out_ready = !w_fifo_empty && (!r_out_valid || out_ready);
    assign w_out_hs       = core_out_valid && core_out_ready;
    assign w_pop          = w_out_hs && (r_out_cnt == LAST);
    assign w_out_mode     = mode_e'(w_fifo_head);

    assign w_scl_real = DW'(scale_shift(32'(core_out_imag), LOG2N, ROUND != 0));
    assign w_scl_imag = DW'(scale_shift(32'(core_out_real), LOG2N, ROUND != 0));

    fft_mode_fifo #(
        .DEPTH(MODE_DEPTH)
    ) u_mode_fifo (
        .clk    (clk),
        .reset  (reset),
        .i_push (w_push),
        .i_din  (inverse_i),
        .i_pop  (w_pop),
        .o_dout (w_fifo_head),
        .o_full (w_fifo_full),
        .o_empty(w_fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_in_cnt  <= '0;
            r_in_mode <= FWD;
        end else if (w_in_hs) begin
            r_in_cnt <= r_in_cnt + 1'b1;
            if (w_in_first) begin
                r_in_mode <= mode_e'(inverse_i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_cnt    <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_frame_done <= 1'b0;
            r_out_real   <= '0;
            r_out_imag   <= '0;
        end else begin
            r_frame_done <= r_out_valid && out_ready && r_out_last;
            if (w_out_hs) begin
                r_out_valid <= 1'b1;
                r_out_last  <= (r_out_cnt == LAST);
                r_out_cnt   <= r_out_cnt + 1'b1;
                if (w_out_mode == INV) begin
                    r_out_real <= w_scl_real;
                    r_out_imag <= w_scl_imag;
                end else begin
                    r_out_real <= core_out_real;
                    r_out_imag <= core_out_imag;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_last   = r_out_last;
    assign out_real   = r_out_real;
    assign out_imag   = r_out_imag;
    assign frame_done = r_frame_done;
    assign busy       = !w_fifo_empty || r_out_valid;

endmodule

// File: tb/tb_fft_dir_stream.sv
// Directed bench for fft_dir_stream: the bench acts as source, identity FFT core and sink.
module tb_fft_dir_stream;
    import fft_dir_pkg::*;

    localparam int DW    = 16;
    localparam int LOG2N = 5;
    localparam int N     = 32;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 inverse_i;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_real;
    logic signed [DW-1:0] in_imag;
    logic                 core_in_valid;
    logic                 core_in_ready;
    logic signed [DW-1:0] core_in_real;
    logic signed [DW-1:0] core_in_imag;
    logic                 core_out_valid;
    logic                 core_out_ready;
    logic signed [DW-1:0] core_out_real;
    logic signed [DW-1:0] core_out_imag;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_real;
    logic signed [DW-1:0] out_imag;
    logic                 out_last;
    logic                 frame_done;
    logic                 busy;

    logic                 in_ready0, core_in_valid0, core_out_ready0;
    logic signed [DW-1:0] core_in_real0, core_in_imag0, out_real0, out_imag0;
    logic                 out_valid0, out_last0, frame_done0, busy0;

    fft_dir_stream #(.DW(DW), .LOG2N(LOG2N), .MODE_DEPTH(2), .ROUND(1)) u_dut (
        .clk(clk), .reset(rst_n), .inverse_i(inverse_i),
        .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
        .core_in_valid(core_in_valid), .core_in_ready(core_in_ready),
        .core_in_real(core_in_real), .core_in_imag(core_in_imag),
        .core_out_valid(core_out_valid), .core_out_ready(core_out_ready),
        .core_out_real(core_out_real), .core_out_imag(core_out_imag),
        .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_imag(out_imag),
        .out_last(out_last), .frame_done(frame_done), .busy(busy)
    );

    fft_dir_stream #(.DW(DW), .LOG2N(LOG2N), .MODE_DEPTH(2), .ROUND(0)) u_dut0 (
        .clk(clk), .reset(rst_n), .inverse_i(inverse_i),
        .in_valid(in_valid), .in_ready(in_ready0), .in_real(in_real), .in_imag(in_imag),
        .core_in_valid(core_in_valid0), .core_in_ready(core_in_ready),
        .core_in_real(core_in_real0), .core_in_imag(core_in_imag0),
        .core_out_valid(core_out_valid), .core_out_ready(core_out_ready0),
        .core_out_real(core_out_real), .core_out_imag(core_out_imag),
        .out_valid(out_valid0), .out_ready(out_ready), .out_real(out_real0), .out_imag(out_imag0),
        .out_last(out_last0), .frame_done(frame_done0), .busy(busy0)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
        int                   ts;
    } core_item_t;

    typedef struct {
        sample_t s;
        logic    last;
    } out_item_t;

    core_item_t core_q[$];
    sample_t    cin_log[$];
    out_item_t  out_q[$];
    out_item_t  out0_q[$];

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int core_hs = 0;
    int fd_cnt = 0;
    bit core_en = 1'b0;
    bit core_taken = 1'b0;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic fail_timeout(input string tag);
        checks++;
        $error("FAIL %s: observed timeout expected progress", tag);
    endtask

    function automatic out_item_t oq(input int k);
        out_item_t d;
        d.s    = 'x;
        d.last = 1'bx;
        if (k < out_q.size()) d = out_q[k];
        return d;
    endfunction

    function automatic out_item_t oq0(input int k);
        out_item_t d;
        d.s    = 'x;
        d.last = 1'bx;
        if (k < out0_q.size()) d = out0_q[k];
        return d;
    endfunction

    function automatic sample_t cq(input int k);
        sample_t d;
        d = 'x;
        if (k < cin_log.size()) d = cin_log[k];
        return d;
    endfunction

    initial forever @(posedge clk) cyc++;

    // Observe handshakes at the falling edge: they complete on the next rising edge.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (core_out_valid && core_out_ready) begin
                if (core_q.size() > 0) core_q.delete(0);
                core_taken = 1'b1;
                core_hs++;
            end
            if (core_in_valid && core_in_ready) begin
                core_q.push_back('{core_in_real, core_in_imag, cyc});
                cin_log.push_back('{core_in_real, core_in_imag});
            end
            if (out_valid && out_ready) out_q.push_back('{'{out_real, out_imag}, out_last});
            if (out_valid0 && out_ready) out0_q.push_back('{'{out_real0, out_imag0}, out_last0});
            if (frame_done) fd_cnt++;
        end
    end

    // Identity core: each accepted sample reappears no earlier than 3 cycles later.
    initial forever begin
        @(posedge clk);
        #2;
        if (!rst_n) begin
            core_q.delete();
            core_out_valid = 1'b0;
        end else if (!(core_out_valid && !core_taken)) begin
            if (core_en && core_q.size() > 0 && cyc >= core_q[0].ts + 3) begin
                core_out_valid = 1'b1;
                core_out_real  = core_q[0].re;
                core_out_imag  = core_q[0].im;
            end else begin
                core_out_valid = 1'b0;
            end
        end
        core_taken = 1'b0;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no completion expected finish");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_sample(input logic inv, input int re, input int im, output bit ok);
        in_valid  = 1'b1;
        inverse_i = inv;
        in_real   = 16'(re);
        in_imag   = 16'(im);
        ok        = 1'b0;
        for (int t = 0; t < 400 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) fail_timeout("in_accept");
    endtask

    task automatic wait_outs(input int n);
        for (int t = 0; t < 3000 && out_q.size() < n; t++) idle(1);
        if (out_q.size() < n) fail_timeout("out_count");
    endtask

    task automatic clear_logs();
        out_q.delete();
        out0_q.delete();
        cin_log.delete();
        fd_cnt  = 0;
        core_hs = 0;
    endtask

    initial begin
        bit        ok;
        out_item_t e;
        sample_t   c;
        logic signed [15:0] h_re, h_im;
        int t2_re[4]  = '{100, -16, 48, -32768};
        int t2_im[4]  = '{-64, 16, 47, -32768};
        int ci_re[4]  = '{-64, 16, 47, -32768};
        int ci_im[4]  = '{-100, 16, -48, 32767};
        int r1_re[4]  = '{-3, 1, -1, 1024};
        int r1_im[4]  = '{-2, 1, 1, -1024};
        int r0_re[4]  = '{-4, 0, -2, 1023};
        int r0_im[4]  = '{-2, 0, 1, -1024};
        int x_re, x_im;

        rst_n = 1'b0; in_valid = 1'b0; inverse_i = 1'b0; in_real = '0; in_imag = '0;
        core_in_ready = 1'b1; core_out_valid = 1'b0; core_out_real = '0; core_out_imag = '0;
        out_ready = 1'b1;
        idle(3);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_busy", busy, 0);
        check("rst_out_real", out_real, 0);
        check("rst_out_imag", out_imag, 0);
        check("rst_core_out_ready", core_out_ready, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        idle(2);

        // Forward frame through the identity core.
        core_en = 1'b1;
        for (int k = 0; k < N; k++) send_sample(1'b0, k, 0, ok);
        in_valid = 1'b0;
        wait_outs(N);
        idle(5);
        check("t1_count", out_q.size(), N);
        for (int k = 0; k < N; k++) begin
            e = oq(k);
            check("t1_sample", {e.s.re, e.s.im, e.last}, {16'(k), 16'(0), (k == N - 1)});
        end
        check("t1_frame_done", fd_cnt, 1);
        check("t1_busy_idle", busy, 0);

        // Inverse frame: pre-processing, rounding and saturation corners, both ROUND settings.
        clear_logs();
        for (int k = 0; k < N; k++) begin
            x_re = (k < 4) ? t2_re[k] : 0;
            x_im = (k < 4) ? t2_im[k] : 0;
            send_sample(1'b1, x_re, x_im, ok);
        end
        in_valid = 1'b0;
        wait_outs(N);
        idle(5);
        for (int k = 0; k < 4; k++) begin
            c = cq(k);
            check("t2_core_in_real", c.re, ci_re[k]);
            check("t2_core_in_imag", c.im, ci_im[k]);
            e = oq(k);
            check("t2_out_round_real", e.s.re, r1_re[k]);
            check("t2_out_round_imag", e.s.im, r1_im[k]);
            e = oq0(k);
            check("t2_out_trunc_real", e.s.re, r0_re[k]);
            check("t2_out_trunc_imag", e.s.im, r0_im[k]);
        end
        e = oq(10);
        check("t2_zero_sample", {e.s.re, e.s.im, e.last}, {16'(0), 16'(0), 1'b0});
        e = oq(N - 1);
        check("t2_last", e.last, 1);
        check("t2_frame_done", fd_cnt, 1);

        // Downstream stall mid-frame.
        clear_logs();
        core_en = 1'b0;
        for (int k = 0; k < N; k++) send_sample(1'b0, 3 * k, 1000 - k, ok);
        in_valid = 1'b0;
        core_en  = 1'b1;
        wait_outs(10);
        out_ready = 1'b0;
        idle(1);
        h_re = out_real;
        h_im = out_imag;
        check("t4_valid_held", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_stall", {out_real, out_imag, out_valid, core_out_ready}, {h_re, h_im, 1'b1, 1'b0});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_outs(N);
        idle(5);
        check("t4_count", out_q.size(), N);
        for (int k = 0; k < N; k++) begin
            e = oq(k);
            check("t4_sample", {e.s.re, e.s.im, e.last}, {16'(3 * k), 16'(1000 - k), (k == N - 1)});
        end
        check("t4_frame_done", fd_cnt, 1);

        // Mode FIFO full: third frame waits for the first frame to drain.
        clear_logs();
        core_en = 1'b0;
        for (int k = 0; k < N; k++) send_sample(1'b0, k, 1, ok);
        for (int k = 0; k < N; k++) send_sample(1'b1, k, 0, ok);
        inverse_i = 1'b0; in_real = '0; in_imag = 16'(2);
        idle(2);
        @(negedge clk);
        check("t5_in_ready_full", in_ready, 0);
        check("t5_core_in_valid_full", core_in_valid, 0);
        check("t5_busy", busy, 1);
        @(posedge clk);
        #1;
        core_en = 1'b1;
        send_sample(1'b0, 0, 2, ok);
        check("t5_accept_after_pop", core_hs >= N, 1);
        for (int k = 1; k < N; k++) send_sample(1'b0, k, 2, ok);
        in_valid = 1'b0;
        wait_outs(3 * N);
        idle(5);
        check("t5_count", out_q.size(), 3 * N);
        for (int k = 0; k < N; k++) begin
            e = oq(k);
            check("t5_frame_a", {e.s.re, e.s.im, e.last}, {16'(k), 16'(1), (k == N - 1)});
            e = oq(N + k);
            check("t5_frame_b", {e.s.re, e.s.im, e.last}, {16'((16 - k) >>> 5), 16'(0), (k == N - 1)});
            e = oq(2 * N + k);
            check("t5_frame_c", {e.s.re, e.s.im, e.last}, {16'(k), 16'(2), (k == N - 1)});
        end
        check("t5_frame_done", fd_cnt, 3);

        // Reset in the middle of an input frame.
        clear_logs();
        core_en = 1'b1;
        for (int k = 0; k < 17; k++) send_sample(1'b1, 50, 60, ok);
        rst_n = 1'b0;
        #1;
        check("t6_out_valid", out_valid, 0);
        check("t6_out_real", out_real, 0);
        check("t6_out_imag", out_imag, 0);
        check("t6_out_last", out_last, 0);
        check("t6_busy", busy, 0);
        check("t6_frame_done", frame_done, 0);
        in_valid = 1'b0;
        idle(2);
        clear_logs();
        rst_n = 1'b1;
        idle(1);
        for (int k = 0; k < N; k++) send_sample(1'b0, k, 7, ok);
        in_valid = 1'b0;
        wait_outs(N);
        idle(5);
        check("t6_count", out_q.size(), N);
        for (int k = 0; k < N; k++) begin
            e = oq(k);
            check("t6_sample", {e.s.re, e.s.im, e.last}, {16'(k), 16'(7), (k == N - 1)});
        end
        check("t6_frame_done_after", fd_cnt, 1);
        check("t6_busy_idle", busy, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fft_dir_stream.md
Name: fft_dir_stream

Overview:
Streaming direction/scaling controller that wraps an external forward-only FFT core and lets each frame run as either a forward or inverse transform. Inverse frames use the swap-conjugate trick: the input is swapped and negated on the way in, swapped back on the way out, and scaled by 1/N. The block sits between the sample source and the FFT core on the input side, and between the core and the consumer on the output side. Direction is selected per frame through a mode FIFO, so frames of mixed direction can be in flight in the core at once.

Parameters:
DW, 16, sample width (signed real and imaginary).
LOG2N, 5, log2 of frame length; N = 2**LOG2N samples per frame.
MODE_DEPTH, 4, depth of the per-frame mode FIFO (power of two, >=2).
ROUND, 1, 1 = round-half-up before the inverse 1/N shift; 0 = truncate by arithmetic shift.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
inverse_i  in  1  direction request, sampled at the first sample of each input frame (1 = inverse).
in_valid  in  1  upstream sample valid.
in_ready  out  1  upstream ready.
in_real, in_imag  in  DW  signed input sample.
core_in_valid  out  1  to core.
core_in_ready  in  1  from core.
core_in_real, core_in_imag  out  DW  pre-processed sample to core.
core_out_valid  in  1  from core.
core_out_ready  out  1  to core.
core_out_real, core_out_imag  in  DW  core result.
out_valid  out  1  downstream valid (registered).
out_ready  in  1  downstream ready.
out_real, out_imag  out  DW  post-processed sample (registered).
out_last  out  1  marks sample N-1 of an output frame.
frame_done  out  1  one-cycle pulse when the last output sample is accepted.
busy  out  1  mode FIFO non-empty or out_valid high.

Behaviour:
- Reset (reset low, async): in_cnt, out_cnt and FIFO pointers cleared; out_valid, out_last, frame_done and busy = 0; out_real, out_imag = 0.
- Input path is combinational, zero latency.
  - Forward mode: core_in_real = in_real, core_in_imag = in_imag.
  - Inverse mode: core_in_real = in_imag, core_in_imag = -in_real. The negation saturates: -(-2**(DW-1)) becomes 2**(DW-1)-1.
  - Mode source: the mode used is inverse_i when in_cnt==0, else the mode latched for the current input frame.
- Gating: in_ready = core_in_ready, except it is forced 0 when in_cnt==0 and the mode FIFO is full.
  - Push is never allowed on a full FIFO, even if a pop occurs in the same cycle.
  - core_in_valid = in_valid && in_ready.
- Input handshake (in_valid && in_ready):
  - in_cnt increments and wraps from N-1 to 0.
  - At in_cnt==0, inverse_i is pushed into the mode FIFO and latched as the current input-frame mode.
  - inverse_i changes mid-frame are ignored.
- Output register:
  - core_out_ready = FIFO non-empty && (!out_valid || out_ready).
  - Each core_out handshake loads the register and sets out_valid. out_valid clears on out_ready with no new load.
  - The mode used for output is the FIFO head.
- Output arithmetic:
  - Forward mode: out = core_out unchanged.
  - Inverse mode: out_real = S(core_out_imag), out_imag = S(core_out_real).
  - S(x) = (x + (ROUND ? 2**(LOG2N-1) : 0)) >>> LOG2N, computed in DW+1 bits, then truncated to DW (always fits).
- out_cnt increments per core_out handshake. out_last is registered with the sample loaded at out_cnt==N-1.
- The FIFO pops on the core_out handshake at out_cnt==N-1.
- frame_done = registered (out_valid && out_ready && out_last).
- While out_ready is held low, out_* hold stable and core_out_ready = 0.
- Latency: 1 cycle from core_out handshake to out_valid.
- If the FIFO is empty, core_out_ready = 0; the core stalls rather than output data having an undefined mode.
- Reset mid-frame: all partial frames are discarded; the next accepted sample starts frame 0.

Decomposition:
- Package fft_dir_pkg holds:
  - mode enum (FWD=0, INV=1);
  - a sample struct {real, imag} of DW bits;
  - functions sat_neg and scale_shift.
- Sub-module fft_mode_fifo: a 1-bit synchronous FIFO of depth MODE_DEPTH with full/empty flags and the same async active-low reset.

Test Plan:
1. Forward frame, identity core model with 3-cycle latency, in_real=k, in_imag=0 for k=0..31 -> out_real=k, out_imag=0, out_last on k=31, exactly one frame_done pulse.
2. Inverse frame, ROUND=1, in=(100,-64) -> core_in=(-64,-100); identity core; out=(-3,-2) [(-100+16)>>>5, (-64+16)>>>5]. ROUND=0 -> out=(-4,-2).
3. Inverse, in_real=-32768 -> core_in_imag=32767 (saturated). in_imag=-32768 passes unchanged to core_in_real.
4. out_ready low 10 cycles mid-frame -> out_* stable, core_out_ready=0, no samples lost or duplicated over 32 outputs.
5. MODE_DEPTH=2, core output stalled, two inverse_i frames pushed (FWD, INV) -> third frame's first sample sees in_ready=0 until the first output frame pops. Output frames come out in FWD then INV order.
6. reset asserted at in_cnt=17 -> outputs 0 immediately, busy=0; the next 32-sample frame is processed correctly with out_last at sample 31.
